// File: rtl/risc_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and
// default parameter values.
package risc_pkg;

  localparam int          DEF_NUM_IRQ    = 8;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0040;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'd4;
  localparam bit          DEF_ROTATE     = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational circular priority encoder: the first set request at or after
// the base index (wrapping) wins.
module int_prio_enc #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] base,
  output logic [IDW-1:0] grant,
  output logic           valid
);

  int unsigned k;

  // Scan from the farthest offset down so the offset closest to base is the
  // last to write grant, and therefore wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = 32'(base) + 32'(i);
      if (k >= 32'(N)) k = k - 32'(N);
      if (req[IDW'(k)]) begin
        grant = IDW'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/risc_int_ctrl.sv
// Interrupt controller: per-source edge/level pending capture, enable gating,
// fixed or rotating priority, and a single-outstanding request/service handshake.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no request outstanding; arbitrate over pending & enable
// ST_REQ     | INT high, int_id/int_vec frozen until int_ack
// ST_SERVICE | CPU servicing int_id; new requests wait for eoi
module risc_int_ctrl
  import risc_pkg::*;
#(
  parameter int                 NUM_IRQ    = DEF_NUM_IRQ,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '1,
  parameter logic [31:0]        VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0]        VEC_STRIDE = DEF_VEC_STRIDE,
  parameter bit                 ROTATE     = DEF_ROTATE,
  localparam int                IDW        = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               en_we,
  input  logic [NUM_IRQ-1:0] en_wdata,
  output logic               INT,
  input  logic               int_ack,
  output logic [31:0]        int_vec,
  output logic [IDW-1:0]     int_id,
  input  logic               eoi,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending
);

  state_t state, state_nxt;

  logic [NUM_IRQ-1:0] en_q, irq_q, pend_q, pend_nxt, ack_clr;
  logic [IDW-1:0]     id_q, rot_ptr, grant, prio_base;
  logic               grant_vld, ack_ok, eoi_ok;

  assign ack_ok    = (state == ST_REQ) && int_ack;
  assign eoi_ok    = (state == ST_SERVICE) && eoi;
  assign prio_base = ROTATE ? rot_ptr : '0;

  int_prio_enc #(.N(NUM_IRQ), .IDW(IDW)) u_prio (
    .req   (pend_q & en_q),
    .base  (prio_base),
    .grant (grant),
    .valid (grant_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (grant_vld) state_nxt = ST_REQ;
      ST_REQ:     if (int_ack)   state_nxt = ST_SERVICE;
      ST_SERVICE: if (eoi)       state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Edge bits: a fresh rising edge beats an ack clear in the same cycle.
  // Level bits simply track irq_in one cycle late.
  always_comb begin
    ack_clr  = ack_ok ? (NUM_IRQ'(1) << id_q) : '0;
    pend_nxt = (EDGE_MASK & ((irq_in & ~irq_q) | (pend_q & ~ack_clr)))
             | (~EDGE_MASK & irq_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= '0;
      irq_q   <= '0;
      pend_q  <= '0;
      id_q    <= '0;
      rot_ptr <= '0;
    end else begin
      if (en_we) en_q <= en_wdata;
      irq_q  <= irq_in;
      pend_q <= pend_nxt;
      if (state == ST_IDLE && grant_vld) id_q <= grant;
      if (ROTATE && eoi_ok)
        rot_ptr <= (id_q == IDW'(NUM_IRQ - 1)) ? '0 : id_q + 1'b1;
    end
  end

  assign INT     = (state == ST_REQ);
  assign busy    = (state != ST_IDLE);
  assign int_id  = id_q;
  assign int_vec = VEC_BASE + 32'(id_q) * VEC_STRIDE;
  assign pending = pend_q;

endmodule

// File: tb/tb_risc_int_ctrl.sv
// Bench for risc_int_ctrl: a fixed-priority instance with a level source on
// bit 4 and a rotating all-edge instance, both checked against a reference model.
module tb_risc_int_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = '0;
  logic       en_we = 1'b0;
  logic [7:0] en_wdata = '0;
  logic       int_ack = 1'b0;
  logic       eoi = 1'b0;

  logic        int_s  [2];
  logic [2:0]  id_s   [2];
  logic [31:0] vec_s  [2];
  logic        busy_s [2];
  logic [7:0]  pend_s [2];

  risc_int_ctrl #(.NUM_IRQ(8), .EDGE_MASK(8'hEF), .ROTATE(1'b0)) dut_fix (
    .clk(clk), .rst(rst), .irq_in(irq_in), .en_we(en_we), .en_wdata(en_wdata),
    .INT(int_s[0]), .int_ack(int_ack), .int_vec(vec_s[0]), .int_id(id_s[0]),
    .eoi(eoi), .busy(busy_s[0]), .pending(pend_s[0]));

  risc_int_ctrl #(.NUM_IRQ(8), .EDGE_MASK(8'hFF), .ROTATE(1'b1)) dut_rot (
    .clk(clk), .rst(rst), .irq_in(irq_in), .en_we(en_we), .en_wdata(en_wdata),
    .INT(int_s[1]), .int_ack(int_ack), .int_vec(vec_s[1]), .int_id(id_s[1]),
    .eoi(eoi), .busy(busy_s[1]), .pending(pend_s[1]));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = idle, 1 = requesting, 2 = in service.
  logic [7:0] m_pend [2];
  logic [7:0] m_en   [2];
  logic [7:0] m_hist [2];
  int         m_phase[2];
  int         m_id   [2];
  int         m_ptr  [2];
  logic [7:0] em     [2];
  bit         rot    [2];

  typedef struct {
    logic [7:0] irq;
    logic       we;
    logic [7:0] wd;
    logic       ack;
    logic       eoi;
    logic       x_int;
    logic [2:0] x_id;
    logic       x_busy;
    logic [7:0] x_pend;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic [7:0] irq, logic we, logic [7:0] wd, logic ack,
                              logic e, logic xi, logic [2:0] xid, logic xb,
                              logic [7:0] xp);
    vec_t v;
    v.irq = irq; v.we = we; v.wd = wd; v.ack = ack; v.eoi = e;
    v.x_int = xi; v.x_id = xid; v.x_busy = xb; v.x_pend = xp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner(int m);
    for (int j = 0; j < 8; j++) begin
      int idx;
      idx = (m_ptr[m] + j) % 8;
      if (m_pend[m][idx] && m_en[m][idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0; m_en[m] = '0; m_hist[m] = '0;
      m_phase[m] = 0; m_id[m] = 0; m_ptr[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      logic [7:0] np;
      int w;
      w = winner(m);
      for (int i = 0; i < 8; i++) begin
        if (em[m][i]) begin
          if (irq_in[i] && !m_hist[m][i])                  np[i] = 1'b1;
          else if (m_phase[m] == 1 && int_ack && m_id[m] == i) np[i] = 1'b0;
          else                                             np[i] = m_pend[m][i];
        end else begin
          np[i] = irq_in[i];
        end
      end
      case (m_phase[m])
        0: if (w >= 0) begin m_id[m] = w; m_phase[m] = 1; end
        1: if (int_ack) m_phase[m] = 2;
        default: if (eoi) begin
          m_phase[m] = 0;
          if (rot[m]) m_ptr[m] = (m_id[m] + 1) % 8;
        end
      endcase
      m_pend[m] = np;
      m_hist[m] = irq_in;
      if (en_we) m_en[m] = en_wdata;
    end
  endtask

  task automatic model_check();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d_int", m),  int_s[m],  (m_phase[m] == 1));
      chk($sformatf("m%0d_busy", m), busy_s[m], (m_phase[m] != 0));
      chk($sformatf("m%0d_id", m),   id_s[m],   m_id[m]);
      chk($sformatf("m%0d_vec", m),  vec_s[m],  32'h40 + 32'(m_id[m]) * 4);
      chk($sformatf("m%0d_pend", m), pend_s[m], m_pend[m]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task automatic idle_in();
    irq_in = '0; en_we = 1'b0; en_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    model_reset();
    #1;
    model_check();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_en(input logic [7:0] v);
    en_we = 1'b1; en_wdata = v;
    tick();
    en_we = 1'b0; en_wdata = '0;
  endtask

  task automatic wait_int(input int m, input int max, input string nm);
    int k;
    k = 0;
    while (!int_s[m] && k < max) begin
      tick();
      k++;
    end
    chk(nm, int_s[m], 1'b1);
  endtask

  initial begin
    em[0] = 8'hEF; em[1] = 8'hFF;
    rot[0] = 1'b0; rot[1] = 1'b1;

    //           irq    we  wd     ack eoi  int id busy pend
    tbl[0]  = mk(8'h00, 1, 8'hFF, 0, 0,   0, 0, 0, 8'h00);
    tbl[1]  = mk(8'h08, 0, 8'h00, 0, 0,   0, 0, 0, 8'h08);
    tbl[2]  = mk(8'h00, 0, 8'h00, 0, 0,   1, 3, 1, 8'h08);
    tbl[3]  = mk(8'h00, 0, 8'h00, 0, 0,   1, 3, 1, 8'h08);
    tbl[4]  = mk(8'h00, 0, 8'h00, 1, 0,   0, 3, 1, 8'h00);
    tbl[5]  = mk(8'h00, 0, 8'h00, 0, 0,   0, 3, 1, 8'h00);
    tbl[6]  = mk(8'h00, 0, 8'h00, 0, 1,   0, 3, 0, 8'h00);
    tbl[7]  = mk(8'h24, 0, 8'h00, 0, 0,   0, 3, 0, 8'h24);
    tbl[8]  = mk(8'h00, 0, 8'h00, 0, 0,   1, 2, 1, 8'h24);
    tbl[9]  = mk(8'h00, 0, 8'h00, 1, 0,   0, 2, 1, 8'h20);
    tbl[10] = mk(8'h00, 0, 8'h00, 0, 1,   0, 2, 0, 8'h20);
    tbl[11] = mk(8'h00, 0, 8'h00, 0, 0,   1, 5, 1, 8'h20);
    tbl[12] = mk(8'h00, 0, 8'h00, 1, 0,   0, 5, 1, 8'h00);
    tbl[13] = mk(8'h00, 0, 8'h00, 0, 1,   0, 5, 0, 8'h00);

    @(negedge clk);
    do_reset();
    chk("rst_vec", vec_s[0], 32'h40);

    // Single source, then two simultaneous sources with fixed priority.
    for (int r = 0; r < 14; r++) begin
      irq_in = tbl[r].irq; en_we = tbl[r].we; en_wdata = tbl[r].wd;
      int_ack = tbl[r].ack; eoi = tbl[r].eoi;
      tick();
      chk($sformatf("tbl%0d_int", r),  int_s[0],  tbl[r].x_int);
      chk($sformatf("tbl%0d_id", r),   id_s[0],   tbl[r].x_id);
      chk($sformatf("tbl%0d_vec", r),  vec_s[0],  32'h40 + 32'(tbl[r].x_id) * 4);
      chk($sformatf("tbl%0d_busy", r), busy_s[0], tbl[r].x_busy);
      chk($sformatf("tbl%0d_pend", r), pend_s[0], tbl[r].x_pend);
    end
    idle_in();

    // Disabled source still accumulates; enabling it raises INT.
    do_reset();
    irq_in = 8'h02; tick();
    irq_in = 8'h00; tick(); tick();
    chk("dis_pend1", pend_s[0][1], 1'b1);
    chk("dis_int", int_s[0], 1'b0);
    set_en(8'h02);
    wait_int(0, 2, "en_int_timeout");
    chk("en_id", id_s[0], 3'd1);

    // Rotating priority: after serving 5, source 6 beats source 2.
    do_reset();
    set_en(8'hFF);
    irq_in = 8'h20; tick();
    irq_in = 8'h00; tick();
    chk("rot_first_id", id_s[1], 3'd5);
    irq_in = 8'h44; tick();
    irq_in = 8'h00; int_ack = 1'b1; tick();
    int_ack = 1'b0; eoi = 1'b1; tick();
    eoi = 1'b0;
    wait_int(1, 2, "rot_int_timeout");
    chk("rot_next_id", id_s[1], 3'd6);
    chk("fix_next_id", id_s[0], 3'd2);

    // Level source held high survives ack and eoi, then re-requests.
    do_reset();
    set_en(8'hFF);
    irq_in = 8'h10;
    wait_int(0, 3, "lvl_int_timeout");
    chk("lvl_id", id_s[0], 3'd4);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("lvl_pend_ack", pend_s[0][4], 1'b1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("lvl_pend_eoi", pend_s[0][4], 1'b1);
    wait_int(0, 2, "lvl_reint_timeout");
    chk("lvl_reid", id_s[0], 3'd4);
    irq_in = 8'h00;

    // New edge on source 3 in the same cycle as its ack: set wins.
    do_reset();
    set_en(8'hFF);
    irq_in = 8'h08; tick();
    irq_in = 8'h00; tick();
    chk("race_int", int_s[0], 1'b1);
    irq_in = 8'h08; int_ack = 1'b1; tick();
    int_ack = 1'b0; irq_in = 8'h00;
    chk("race_pend", pend_s[0][3], 1'b1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    wait_int(0, 2, "race_reint_timeout");
    chk("race_reid", id_s[0], 3'd3);

    // Reset during service, then a stray eoi and an un-enabled edge.
    do_reset();
    set_en(8'hFF);
    irq_in = 8'h08; tick();
    irq_in = 8'h00; tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("svc_busy", busy_s[0], 1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_int", int_s[0], 1'b0);
    chk("mid_rst_busy", busy_s[0], 1'b0);
    chk("mid_rst_pend", pend_s[0], 8'h00);
    chk("mid_rst_id", id_s[0], 3'd0);
    chk("mid_rst_vec", vec_s[0], 32'h40);
    @(negedge clk);
    rst = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("stray_eoi_busy", busy_s[0], 1'b0);
    irq_in = 8'h08; tick();
    irq_in = 8'h00; tick(); tick();
    chk("rearm_int", int_s[0], 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      irq_in   = 8'($urandom);
      en_we    = ($urandom_range(0, 15) == 0);
      en_wdata = 8'($urandom);
      int_ack  = ($urandom_range(0, 2) == 0);
      eoi      = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/risc_int_ctrl.md
RISC_INT_CTRL -- requirements
Module: risc_int_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8, SHALL set the number of interrupt sources (2..32).
REQ-002 Parameter EDGE_MASK, default all ones, SHALL select per-source trigger mode: bit=1 rising-edge, bit=0 level-high.
REQ-003 Parameter VEC_BASE, default 32'h0000_0040, SHALL set the vector address of source 0.
REQ-004 Parameter VEC_STRIDE, default 4, SHALL set the vector spacing between sources.
REQ-005 Parameter ROTATE, default 0, SHALL select priority: 0 fixed (lowest index wins), 1 rotating.
REQ-006 Ports:
- clk  in  1  system clock; one clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- irq_in  in  NUM_IRQ  interrupt sources, synchronous to clk.
- en_we  in  1  enable-register write strobe.
- en_wdata  in  NUM_IRQ  enable value, 1 = source enabled.
- INT  out  1  interrupt request to the CPU.
- int_ack  in  1  CPU accepts the request.
- int_vec  out  32  vector of the granted source.
- int_id  out  clog2(NUM_IRQ)  granted source index.
- eoi  in  1  CPU end-of-interrupt.
- busy  out  1  high while a request is outstanding or in service.
- pending  out  NUM_IRQ  pending register.

Function
REQ-007 Edge source pending bit SHALL set on the cycle irq_in is sampled high after having been sampled low, and SHALL clear only on int_ack of that source.
REQ-008 Level source pending bit SHALL equal irq_in registered by one cycle; int_ack SHALL NOT clear it.
REQ-009 If a set and an ack-clear hit the same edge bit in one cycle, set SHALL win.
REQ-010 Enable register SHALL gate arbitration only; pending bits SHALL still accumulate while disabled.
REQ-011 The FSM SHALL have states IDLE, REQ, SERVICE.
REQ-012 IDLE: when any (pending & enable) bit is set, the FSM SHALL latch the winner into int_id, go to REQ, and assert INT.
REQ-013 REQ: INT, int_id and int_vec SHALL be held stable until int_ack; enable or pending changes SHALL NOT withdraw or retarget the request.
REQ-014 On int_ack in REQ, the FSM SHALL go to SERVICE and deassert INT on the next cycle.
REQ-015 SERVICE: on eoi the FSM SHALL return to IDLE; no nesting, and new requests SHALL wait.
REQ-016 int_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-017 int_vec SHALL equal VEC_BASE + int_id*VEC_STRIDE, modulo 2^32.
REQ-018 Latency: irq_in sampled high at edge k SHALL give INT high after edge k+1 when the FSM is IDLE.
REQ-019 ROTATE=1: on eoi, the highest-priority index SHALL become int_id+1, wrapping from NUM_IRQ-1 to 0.
REQ-020 busy SHALL be high in REQ and SERVICE.

Reset
REQ-021 rst SHALL force IDLE; INT=0, int_id=0, int_vec=VEC_BASE, busy=0, pending=0, enable=0, rotate pointer=0, and edge-history regs=0.
REQ-022 rst asserted mid-REQ or mid-SERVICE SHALL abandon the transaction immediately, with no further INT until re-armed.

Structure
REQ-023 State encoding and default parameter values SHALL live in shared package risc_pkg.
REQ-024 Arbitration SHALL be one sub-module, int_prio_enc: request vector plus base index in, grant index and valid out, combinational.

Verification
REQ-025 Enable=8'hFF, pulse irq_in[3] -> INT after 2 edges, int_id=3, int_vec=32'h4C; ack -> pending[3]=0; eoi -> busy=0.
REQ-026 Fixed priority, irq_in[5] and [2] together -> grant 2 first, then 5 after eoi; ROTATE=1 after serving 5 with 2 and 6 pending -> 6 before 2.
REQ-027 Enable=0, pulse irq_in[1] -> pending[1]=1 and INT=0; write enable=8'h02 -> INT within 2 cycles with int_id=1.
REQ-028 Level source (EDGE_MASK bit 4=0) held high through ack and eoi -> pending[4] stays 1 and INT re-asserts with id 4.
REQ-029 New edge on source 3 in the same cycle as ack of 3 -> pending[3] stays 1; it is re-served after eoi.
REQ-030 rst asserted in SERVICE -> all outputs at reset values next sample; a stray eoi afterwards has no effect.
